// File: rtl/lane_centroid_if.sv
// Pixel-stream input and centroid result bundle for lane_centroid.
// The master side feeds edge magnitudes; the slave side is the centroid engine.
interface lane_centroid_if #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
);
    localparam int CW    = $clog2(IMG_W);
    localparam int CNT_W = $clog2(IMG_W * IMG_H) + 1;

    logic [3:0]       pixel_in;
    logic             in_ready;
    logic [CW-1:0]    centroid;
    logic             centroid_valid;
    logic             no_edge;
    logic [CNT_W-1:0] edge_count;
    logic             busy;
    logic             overrun;

    modport master (
        output pixel_in, in_ready,
        input  centroid, centroid_valid, no_edge, edge_count, busy, overrun
    );

    modport slave (
        input  pixel_in, in_ready,
        output centroid, centroid_valid, no_edge, edge_count, busy, overrun
    );
endinterface

// File: rtl/lane_centroid.sv
// Per-frame mean column of edge pixels inside a row band, computed at end of
// frame by a restoring divider and published as a steering centroid.
module lane_centroid #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int THRESH    = 8,
    parameter int ROW_START = 240,
    parameter int ROW_END   = 479,
    parameter int MIN_COUNT = 16
) (
    input logic           clk,
    input logic           rst_n,
    lane_centroid_if.slave bus
);
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int CW    = XW;
    localparam int CNT_W = $clog2(IMG_W * IMG_H) + 1;
    localparam int SUM_W = $clog2(IMG_W * IMG_W * IMG_H / 2) + 1;
    localparam int BIT_W = $clog2(SUM_W + 1);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, CHECK, DIVIDE, DONE} state_t;

    state_t           state_q, state_d;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic [SUM_W-1:0] sum_acc, sum_snap;
    logic [CNT_W-1:0] cnt_acc, cnt_snap;
    logic [SUM_W-1:0] dividend_q;
    logic [CNT_W-1:0] rem_q;
    logic [BIT_W-1:0] bit_q;
    logic [CW-1:0]    centroid_q;
    logic             no_edge_q;
    logic [CNT_W-1:0] edge_count_q;
    logic             overrun_q;

    logic             eof, in_band, edge_hit, low_count;
    logic [CNT_W:0]   rem_shift;
    logic             fits;
    logic [CNT_W-1:0] rem_next;
    logic [SUM_W-1:0] quot_next;
    logic             div_load, div_step, div_last, busy_c, valid_c;

    assign eof       = bus.in_ready && (x_q == X_LAST) && (y_q == Y_LAST);
    assign in_band   = (int'(y_q) >= ROW_START) && (int'(y_q) <= ROW_END);
    assign edge_hit  = bus.in_ready && (int'(bus.pixel_in) >= THRESH) && in_band;
    assign low_count = int'(cnt_snap) < MIN_COUNT;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    assign rem_shift = {rem_q, dividend_q[SUM_W-1]};
    assign fits      = rem_shift >= {1'b0, cnt_snap};
    assign rem_next  = fits ? CNT_W'(rem_shift - {1'b0, cnt_snap}) : CNT_W'(rem_shift);
    assign quot_next = {dividend_q[SUM_W-2:0], fits};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (bus.in_ready) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    // Accumulation never stalls; a frame ending while the FSM is busy is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_acc   <= '0;
            cnt_acc   <= '0;
            sum_snap  <= '0;
            cnt_snap  <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= eof && (state_q != IDLE);
            if (eof) begin
                sum_acc <= '0;
                cnt_acc <= '0;
                if (state_q == IDLE) begin
                    sum_snap <= sum_acc + (edge_hit ? SUM_W'(x_q) : SUM_W'(0));
                    cnt_snap <= cnt_acc + CNT_W'(edge_hit);
                end
            end else if (edge_hit) begin
                sum_acc <= sum_acc + SUM_W'(x_q);
                cnt_acc <= cnt_acc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        div_load = 1'b0;
        div_step = 1'b0;
        div_last = 1'b0;
        busy_c   = 1'b0;
        valid_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (eof) state_d = CHECK;
            end
            CHECK: begin
                if (low_count) begin
                    state_d = DONE;
                end else begin
                    state_d  = DIVIDE;
                    div_load = 1'b1;
                end
            end
            DIVIDE: begin
                busy_c   = 1'b1;
                div_step = 1'b1;
                if (bit_q == BIT_W'(SUM_W - 1)) begin
                    div_last = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                valid_c = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Results land on the edge entering DONE so they are stable while valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend_q   <= '0;
            rem_q        <= '0;
            bit_q        <= '0;
            centroid_q   <= CW'(IMG_W / 2);
            no_edge_q    <= 1'b1;
            edge_count_q <= '0;
        end else begin
            if (state_q == CHECK && low_count) begin
                no_edge_q    <= 1'b1;
                edge_count_q <= cnt_snap;
            end
            if (div_load) begin
                dividend_q <= sum_snap;
                rem_q      <= '0;
                bit_q      <= '0;
                no_edge_q  <= 1'b0;
            end
            if (div_step) begin
                dividend_q <= quot_next;
                rem_q      <= rem_next;
                bit_q      <= bit_q + 1'b1;
                if (div_last) begin
                    centroid_q   <= quot_next[CW-1:0];
                    edge_count_q <= cnt_snap;
                end
            end
        end
    end

    assign bus.centroid       = centroid_q;
    assign bus.centroid_valid = valid_c;
    assign bus.no_edge        = no_edge_q;
    assign bus.edge_count     = edge_count_q;
    assign bus.busy           = busy_c;
    assign bus.overrun        = overrun_q;
endmodule

// File: tb/tb_lane_centroid.sv
// Directed bench for lane_centroid on a 16x8 build (band rows 4..7) plus a
// 3x2 build whose frames are short enough to overrun the divider.
module tb_lane_centroid;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   valid_seen = 0;

    always #5 clk = ~clk;

    lane_centroid_if #(.IMG_W(16), .IMG_H(8)) m_if ();
    lane_centroid_if #(.IMG_W(3),  .IMG_H(2)) t_if ();

    lane_centroid #(
        .IMG_W(16), .IMG_H(8), .THRESH(8), .ROW_START(4), .ROW_END(7), .MIN_COUNT(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(m_if.slave)
    );

    lane_centroid #(
        .IMG_W(3), .IMG_H(2), .THRESH(8), .ROW_START(0), .ROW_END(1), .MIN_COUNT(1)
    ) u_tiny (
        .clk(clk), .rst_n(rst_n), .bus(t_if.slave)
    );

    always @(negedge clk) if (m_if.centroid_valid) valid_seen++;

    function automatic logic [3:0] pix(input int mode, input int x, input int y);
        case (mode)
            1:       return (x == 5) ? 4'd15 : 4'd0;
            2:       return (x == 5 || x == 10) ? 4'd15 : 4'd0;
            3:       return (x == 3 && y < 4) ? 4'd15 : 4'd7;
            4:       return (x == 9 && y >= 5) ? 4'd8 : 4'd0;
            5:       return (x == 9) ? 4'd8 : 4'd0;
            default: return 4'd0;
        endcase
    endfunction

    task automatic drive_pixels(input int mode, input int gap, input int npix);
        for (int i = 0; i < npix; i++) begin
            @(negedge clk);
            m_if.pixel_in = pix(mode, i % 16, i / 16);
            m_if.in_ready = 1'b1;
            if ((i % 16) == 15 && gap > 0 && i != 127) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    m_if.in_ready = 1'b0;
                    m_if.pixel_in = 4'd15;
                end
            end
        end
    endtask

    task automatic wait_result(output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            m_if.in_ready = 1'b0;
            m_if.pixel_in = 4'd0;
            if (m_if.centroid_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        m_if.pixel_in = 4'd0;
        m_if.in_ready = 1'b0;
        t_if.pixel_in = 4'd0;
        t_if.in_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (m_if.centroid !== 4'd8) begin bad++; $display("[TB] FAIL reset_centroid: got %0d want 8", m_if.centroid); end
        total++; if (m_if.no_edge !== 1'b1) begin bad++; $display("[TB] FAIL reset_no_edge: got %b want 1", m_if.no_edge); end
        total++; if (m_if.edge_count !== 8'd0) begin bad++; $display("[TB] FAIL reset_edge_count: got %0d want 0", m_if.edge_count); end
        total++; if (m_if.busy !== 1'b0 || m_if.centroid_valid !== 1'b0 || m_if.overrun !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_flags: busy=%b valid=%b overrun=%b want 0 0 0", m_if.busy, m_if.centroid_valid, m_if.overrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_line();
        int lat;
        drive_pixels(1, 0, 128);
        wait_result(lat);
        total++; if (lat !== 13) begin bad++; $display("[TB] FAIL single_latency: got %0d want 13", lat); end
        total++; if (m_if.centroid !== 4'd5) begin bad++; $display("[TB] FAIL single_centroid: got %0d want 5", m_if.centroid); end
        total++; if (m_if.edge_count !== 8'd4) begin bad++; $display("[TB] FAIL single_edge_count: got %0d want 4", m_if.edge_count); end
        total++; if (m_if.no_edge !== 1'b0) begin bad++; $display("[TB] FAIL single_no_edge: got %b want 0", m_if.no_edge); end
        @(negedge clk);
        total++; if (m_if.centroid_valid !== 1'b0 || m_if.centroid !== 4'd5) begin
            bad++; $display("[TB] FAIL single_pulse_hold: valid=%b centroid=%0d want 0 5", m_if.centroid_valid, m_if.centroid);
        end
    endtask

    task automatic test_two_lines();
        int lat;
        drive_pixels(2, 0, 128);
        wait_result(lat);
        total++; if (lat !== 13) begin bad++; $display("[TB] FAIL two_latency: got %0d want 13", lat); end
        total++; if (m_if.centroid !== 4'd7) begin bad++; $display("[TB] FAIL two_centroid_floor: got %0d want 7", m_if.centroid); end
        total++; if (m_if.edge_count !== 8'd8) begin bad++; $display("[TB] FAIL two_edge_count: got %0d want 8", m_if.edge_count); end
    endtask

    task automatic test_threshold_band();
        int lat;
        drive_pixels(3, 0, 128);
        wait_result(lat);
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL band_latency: got %0d want 2", lat); end
        total++; if (m_if.no_edge !== 1'b1) begin bad++; $display("[TB] FAIL band_no_edge: got %b want 1", m_if.no_edge); end
        total++; if (m_if.centroid !== 4'd7) begin bad++; $display("[TB] FAIL band_centroid_hold: got %0d want 7", m_if.centroid); end
        total++; if (m_if.edge_count !== 8'd0) begin bad++; $display("[TB] FAIL band_edge_count: got %0d want 0", m_if.edge_count); end
    endtask

    task automatic test_min_count();
        int lat;
        drive_pixels(4, 0, 128);
        wait_result(lat);
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL below_min_latency: got %0d want 2", lat); end
        total++; if (m_if.no_edge !== 1'b1 || m_if.edge_count !== 8'd3) begin
            bad++; $display("[TB] FAIL below_min_result: no_edge=%b count=%0d want 1 3", m_if.no_edge, m_if.edge_count);
        end
        drive_pixels(5, 0, 128);
        wait_result(lat);
        total++; if (lat !== 13) begin bad++; $display("[TB] FAIL at_min_latency: got %0d want 13", lat); end
        total++; if (m_if.centroid !== 4'd9 || m_if.edge_count !== 8'd4 || m_if.no_edge !== 1'b0) begin
            bad++; $display("[TB] FAIL at_min_result: centroid=%0d count=%0d no_edge=%b want 9 4 0", m_if.centroid, m_if.edge_count, m_if.no_edge);
        end
    endtask

    task automatic test_blanking();
        int lat;
        drive_pixels(1, 5, 128);
        wait_result(lat);
        total++; if (lat !== 13) begin bad++; $display("[TB] FAIL blank_latency: got %0d want 13", lat); end
        total++; if (m_if.centroid !== 4'd5 || m_if.edge_count !== 8'd4) begin
            bad++; $display("[TB] FAIL blank_result: centroid=%0d count=%0d want 5 4", m_if.centroid, m_if.edge_count);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int v0;
        drive_pixels(2, 0, 128);
        repeat (4) begin
            @(negedge clk);
            m_if.in_ready = 1'b0;
        end
        total++; if (m_if.busy !== 1'b1) begin bad++; $display("[TB] FAIL abort_busy_before: got %b want 1", m_if.busy); end
        rst_n = 1'b0;
        #1;
        total++; if (m_if.centroid !== 4'd8 || m_if.busy !== 1'b0 || m_if.no_edge !== 1'b1) begin
            bad++; $display("[TB] FAIL abort_async_clear: centroid=%0d busy=%b no_edge=%b want 8 0 1", m_if.centroid, m_if.busy, m_if.no_edge);
        end
        @(negedge clk);
        rst_n = 1'b1;
        v0 = valid_seen;
        repeat (20) @(negedge clk);
        total++; if (valid_seen !== v0) begin bad++; $display("[TB] FAIL abort_no_valid: got %0d pulses want 0", valid_seen - v0); end
        drive_pixels(1, 0, 50);
        @(negedge clk);
        m_if.in_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive_pixels(1, 0, 128);
        wait_result(lat);
        total++; if (lat !== 13) begin bad++; $display("[TB] FAIL post_reset_latency: got %0d want 13", lat); end
        total++; if (m_if.centroid !== 4'd5 || m_if.edge_count !== 8'd4) begin
            bad++; $display("[TB] FAIL post_reset_result: centroid=%0d count=%0d want 5 4", m_if.centroid, m_if.edge_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [18] = '{4'd15, 4'd15, 4'd0,  4'd15, 4'd0,  4'd0,
                                 4'd0,  4'd0,  4'd15, 4'd0,  4'd0,  4'd15,
                                 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
        int vcount = 0;
        int ocount = 0;
        int c1 = -1, e1 = -1, c2 = -1, e2 = -1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (t_if.centroid_valid) begin
                vcount++;
                if (vcount == 1) begin c1 = int'(t_if.centroid); e1 = int'(t_if.edge_count); end
                if (vcount == 2) begin c2 = int'(t_if.centroid); e2 = int'(t_if.edge_count); end
            end
            if (t_if.overrun) ocount++;
            if (k < 18) begin
                t_if.pixel_in = seq[k];
                t_if.in_ready = 1'b1;
            end else begin
                t_if.pixel_in = 4'd0;
                t_if.in_ready = 1'b0;
            end
        end
        total++; if (ocount !== 1) begin bad++; $display("[TB] FAIL b2b_overrun_pulses: got %0d want 1", ocount); end
        total++; if (vcount !== 2) begin bad++; $display("[TB] FAIL b2b_valid_pulses: got %0d want 2", vcount); end
        total++; if (c1 !== 0 || e1 !== 3) begin bad++; $display("[TB] FAIL b2b_first_frame: centroid=%0d count=%0d want 0 3", c1, e1); end
        total++; if (c2 !== 1 || e2 !== 6) begin bad++; $display("[TB] FAIL b2b_third_frame: centroid=%0d count=%0d want 1 6", c2, e2); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_line();
        test_two_lines();
        test_threshold_band();
        test_min_count();
        test_blanking();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
